data_cache_writer: RTL and testbench
====================================

DATA_CACHE_WRITER -- requirements
Module: data_cache_writer

Interface
REQ-001 SHALL have parameters: ADDRESS_WIDTH 32 (byte address width); DATA_WIDTH 32 (word width); TAG_WIDTH 27 (tag = addr[31:5]); SET_WIDTH 3 (set = addr[4:2], 8 sets); SRAM_WIDTH 60 (line = {V, tag, data}).
REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; addr[1:0] ignored.
- req_wdata  in  32  store data.
- req_ready  out  1  controller can accept a request.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load data, valid with resp_valid.
- flush_req  in  1  request invalidation of all sets.
- flush_done  out  1  one-cycle pulse at end of sweep.
- lu_set  out  3  set index to the lookup array.
- lu_V  in  1  registered valid bit of lu_set (1-cycle read latency).
- lu_tag  in  27  registered tag of lu_set.
- lu_data  in  32  registered data of lu_set.
- wr_en  out  1  array line write strobe.
- wr_set  out  3  set being written.
- wr_line  out  60  {V, tag, data} written.
- mem_req  out  1  main-memory request, held until mem_ack.
- mem_we  out  1  1 = memory write.
- mem_addr  out  32  word-aligned address (addr[1:0] = 0).
- mem_wdata  out  32  memory write data.
- mem_ack  in  1  single-cycle memory completion.
- mem_rdata  in  32  read data, valid with mem_ack.

Function
REQ-003 SHALL implement FSM states FLUSH, IDLE, LOOKUP, COMPARE, FETCH, WRITE_MEM, RESP.
REQ-004 SHALL assert req_ready only in IDLE with flush_req low; request accepted on the edge where req_valid && req_ready; addr/wdata/write registered then; next state LOOKUP.
REQ-005 In IDLE, flush_req high SHALL take priority over req_valid -> FLUSH with sweep counter 0.
REQ-006 FLUSH SHALL write one set per cycle: wr_en=1, wr_set=counter, wr_line=0; counter 0..7 (8 cycles); at counter 7 -> IDLE and pulse flush_done for the following cycle.
REQ-007 lu_set SHALL equal the registered request set in LOOKUP and COMPARE; LOOKUP lasts exactly 1 cycle to absorb array read latency.
REQ-008 COMPARE: hit = lu_V && (lu_tag == req tag). Load hit -> RESP with resp_rdata = lu_data. Load miss -> FETCH. Store (hit or miss) -> WRITE_MEM.
REQ-009 FETCH SHALL hold mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00} until mem_ack; on the mem_ack cycle wr_en=1, wr_line={1, tag, mem_rdata}, capture mem_rdata -> RESP.
REQ-010 WRITE_MEM (write-through, write-allocate) SHALL hold mem_req=1, mem_we=1, mem_wdata=req_wdata until mem_ack; on the mem_ack cycle wr_en=1, wr_line={1, tag, req_wdata} -> RESP.
REQ-011 RESP SHALL last 1 cycle with resp_valid=1 (resp_rdata don't-care for stores) -> IDLE.
REQ-012 Load-hit latency SHALL be 3 cycles from accept edge to resp_valid; miss = 3 + mem_ack wait cycles.
REQ-013 mem_ack outside FETCH/WRITE_MEM SHALL be ignored; wr_en SHALL be 0 in all states/cycles not listed in REQ-006/009/010.
REQ-014 flush_req arriving while busy SHALL be serviced only on return to IDLE, if still high; resp_valid and flush_done SHALL never coincide.

Reset
REQ-015 While rst=1: all outputs 0 (req_ready, resp_valid, resp_rdata, flush_done, wr_en, wr_set, wr_line, mem_req, mem_we, mem_addr, mem_wdata, lu_set); state <- FLUSH, counter <- 0.
REQ-016 Reset SHALL abort any state, including FETCH/WRITE_MEM with mem_req high; mem_req drops the first cycle rst is sampled high; pending ack discarded.
REQ-017 First cycle after rst deasserts SHALL be FLUSH set 0; req_ready stays 0 until the 8-cycle sweep completes.

Verification
REQ-018 Release reset -> wr_en high 8 consecutive cycles, wr_set 0..7, wr_line=0, then flush_done pulse, then req_ready=1.
REQ-019 Load 0x0000_0014 after flush, memory returns 0xDEAD_BEEF after 4 cycles -> mem_req held 4 cycles, mem_addr 0x14; write set 5 line {1, 0x0000000, 0xDEADBEEF}; resp_rdata 0xDEADBEEF.
REQ-020 Repeat load 0x14 -> no mem_req; resp_valid exactly 3 cycles after accept, rdata 0xDEADBEEF.
REQ-021 Store 0xCAFE_0001 to 0x34 (set 5, tag 1) -> mem write 0x34; line set 5 replaced {1, 1, 0xCAFE0001}; subsequent load 0x14 misses and refetches.
REQ-022 Assert rst during FETCH with mem_req high -> mem_req 0 next cycle; late mem_ack ignored; full 8-set flush rerun.
REQ-023 flush_req and req_valid both high in IDLE -> flush executes first, request accepted after flush_done with correct response.

Source files
------------

// File: rtl/data_cache_writer_if.sv
// Bundle of CPU request/response, lookup-array and main-memory signals
// around the direct-mapped write-through data cache controller.
// The master modport is the controller; the slave modport is its
// environment (CPU, line array and memory).
interface data_cache_writer_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 27,
  parameter int SET_WIDTH     = 3,
  parameter int SRAM_WIDTH    = 60
);
  logic                     req_valid;
  logic                     req_write;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     req_ready;
  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     flush_req;
  logic                     flush_done;
  logic [SET_WIDTH-1:0]     lu_set;
  logic                     lu_V;
  logic [TAG_WIDTH-1:0]     lu_tag;
  logic [DATA_WIDTH-1:0]    lu_data;
  logic                     wr_en;
  logic [SET_WIDTH-1:0]     wr_set;
  logic [SRAM_WIDTH-1:0]    wr_line;
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_ack;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, flush_req,
           lu_V, lu_tag, lu_data, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, flush_done, lu_set,
           wr_en, wr_set, wr_line, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, flush_req,
           lu_V, lu_tag, lu_data, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, flush_done, lu_set,
           wr_en, wr_set, wr_line, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_cache_writer.sv
// Direct-mapped, write-through / write-allocate data cache controller.
// Sweeps (invalidates) all sets after reset or on flush_req, then serves
// one load/store at a time against an external line array with a
// one-cycle registered read port and a single-request main memory.
module data_cache_writer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 27,
  parameter int SET_WIDTH     = 3,
  parameter int SRAM_WIDTH    = 60
) (
  input  logic               clk,
  input  logic               rst,
  data_cache_writer_if.master bus
);
  typedef enum logic [2:0] {
    ST_FLUSH     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_LOOKUP    = 3'd2,
    ST_COMPARE   = 3'd3,
    ST_FETCH     = 3'd4,
    ST_WRITE_MEM = 3'd5,
    ST_RESP      = 3'd6
  } state_t;

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic [SET_WIDTH-1:0]     cnt_r;
  logic [ADDRESS_WIDTH-1:2] addr_r;
  logic [DATA_WIDTH-1:0]    wdata_r;
  logic [DATA_WIDTH-1:0]    rdata_r;
  logic                     write_r;
  logic                     done_r;
  logic [TAG_WIDTH-1:0]     tag_s;
  logic [SET_WIDTH-1:0]     set_s;
  logic                     hit_s;
  logic                     accept_s;
  logic                     sweep_last_s;

  // Builds an array line {valid, tag, data}.
  function automatic logic [SRAM_WIDTH-1:0] pack_line(
    input logic                 v,
    input logic [TAG_WIDTH-1:0] t,
    input logic [DATA_WIDTH-1:0] d
  );
    return {v, t, d};
  endfunction

  assign tag_s        = addr_r[ADDRESS_WIDTH-1 -: TAG_WIDTH];
  assign set_s        = addr_r[SET_WIDTH+1:2];
  assign hit_s        = bus.lu_V && (bus.lu_tag == tag_s);
  assign accept_s     = (state_r == ST_IDLE) && !bus.flush_req && bus.req_valid;
  assign sweep_last_s = (cnt_r == {SET_WIDTH{1'b1}});

  // State register and flush sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FLUSH;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_FLUSH) begin
        cnt_r <= cnt_r + {{(SET_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= '0;
      end
    end
  end

  // Request capture, response data capture and the flush_done pulse flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= '0;
      wdata_r <= '0;
      write_r <= 1'b0;
      rdata_r <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= (state_r == ST_FLUSH) && sweep_last_s;
      if (accept_s) begin
        addr_r  <= bus.req_addr[ADDRESS_WIDTH-1:2];
        wdata_r <= bus.req_wdata;
        write_r <= bus.req_write;
      end
      if ((state_r == ST_COMPARE) && !write_r && hit_s) begin
        rdata_r <= bus.lu_data;
      end else if ((state_r == ST_FETCH) && bus.mem_ack) begin
        rdata_r <= bus.mem_rdata;
      end
    end
  end

  // Next-state decode; flush_req wins over a pending request in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FLUSH: begin
        if (sweep_last_s) state_nxt_s = ST_IDLE;
        else              state_nxt_s = ST_FLUSH;
      end
      ST_IDLE: begin
        if (bus.flush_req)      state_nxt_s = ST_FLUSH;
        else if (bus.req_valid) state_nxt_s = ST_LOOKUP;
        else                    state_nxt_s = ST_IDLE;
      end
      ST_LOOKUP:  state_nxt_s = ST_COMPARE;
      ST_COMPARE: begin
        if (write_r)    state_nxt_s = ST_WRITE_MEM;
        else if (hit_s) state_nxt_s = ST_RESP;
        else            state_nxt_s = ST_FETCH;
      end
      ST_FETCH, ST_WRITE_MEM: begin
        if (bus.mem_ack) state_nxt_s = ST_RESP;
        else             state_nxt_s = state_r;
      end
      ST_RESP:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_FLUSH;
    endcase
  end

  // Output decode from state; everything is forced low while rst is high
  // so an in-flight memory request is dropped immediately.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.flush_done = 1'b0;
    bus.lu_set     = '0;
    bus.wr_en      = 1'b0;
    bus.wr_set     = '0;
    bus.wr_line    = '0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (rst) begin
      bus.req_ready = 1'b0;
    end else begin
      bus.flush_done = done_r;
      case (state_r)
        ST_FLUSH: begin
          bus.wr_en  = 1'b1;
          bus.wr_set = cnt_r;
        end
        ST_IDLE: bus.req_ready = !bus.flush_req;
        ST_LOOKUP, ST_COMPARE: bus.lu_set = set_s;
        ST_FETCH: begin
          bus.mem_req  = 1'b1;
          bus.mem_addr = {addr_r, 2'b00};
          if (bus.mem_ack) begin
            bus.wr_en   = 1'b1;
            bus.wr_set  = set_s;
            bus.wr_line = pack_line(1'b1, tag_s, bus.mem_rdata);
          end else begin
            bus.wr_en = 1'b0;
          end
        end
        ST_WRITE_MEM: begin
          bus.mem_req   = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = {addr_r, 2'b00};
          bus.mem_wdata = wdata_r;
          if (bus.mem_ack) begin
            bus.wr_en   = 1'b1;
            bus.wr_set  = set_s;
            bus.wr_line = pack_line(1'b1, tag_s, wdata_r);
          end else begin
            bus.wr_en = 1'b0;
          end
        end
        ST_RESP: begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = rdata_r;
        end
        default: bus.req_ready = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_data_cache_writer.sv
// Self-checking bench for data_cache_writer: directed scenarios plus
// randomized loads/stores checked against a transaction-level cache and
// memory model.
module tb_data_cache_writer;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  data_cache_writer_if bus ();

  data_cache_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line array environment: registered read, written on wr_en.
  logic        arr_v    [8];
  logic [26:0] arr_tag  [8];
  logic [31:0] arr_data [8];

  always @(posedge clk) begin
    bus.lu_V    <= arr_v[bus.lu_set];
    bus.lu_tag  <= arr_tag[bus.lu_set];
    bus.lu_data <= arr_data[bus.lu_set];
    if (bus.wr_en) begin
      arr_v[bus.wr_set]    <= bus.wr_line[59];
      arr_tag[bus.wr_set]  <= bus.wr_line[58:32];
      arr_data[bus.wr_set] <= bus.wr_line[31:0];
    end
  end

  // Reference model: cache contents and main memory.
  bit          rc_v    [8];
  logic [26:0] rc_tag  [8];
  logic [31:0] rc_data [8];
  logic [31:0] ref_mem [logic [31:0]];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) rc_v[i] = 1'b0;
  endtask

  // Called in the first FLUSH cycle; checks the 8-set sweep and flush_done.
  task automatic check_sweep();
    for (int i = 0; i < 8; i++) begin
      #1;
      check_val("sweep_wr_en", bus.wr_en, 1);
      check_val("sweep_wr_set", bus.wr_set, i);
      check_val("sweep_wr_line", bus.wr_line, 0);
      check_val("sweep_ready", bus.req_ready, 0);
      check_val("sweep_done_early", bus.flush_done, 0);
      @(negedge clk);
    end
    #1;
    check_val("flush_done", bus.flush_done, 1);
    check_val("flush_done_resp", bus.resp_valid, 0);
    check_val("flush_done_wr_en", bus.wr_en, 0);
    model_clear();
  endtask

  // Idle-cycle flush request.
  task automatic do_flush();
    bus.flush_req = 1'b1;
    @(negedge clk);
    bus.flush_req = 1'b0;
    check_sweep();
    @(negedge clk);
  endtask

  task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d, input int dly);
    int          set;
    int          lat;
    int          nmem;
    int          nwr;
    int          wt;
    int          exp_lat;
    logic [26:0] tg;
    logic [31:0] wa;
    logic [31:0] exp_data;
    logic [59:0] exp_line;
    bit          hit;
    bit          need;
    bit          got_resp;
    wa  = {a[31:2], 2'b00};
    set = (a >> 2) % 8;
    tg  = 27'(a >> 5);
    hit = rc_v[set] && (rc_tag[set] == tg);
    if (!ref_mem.exists(wa)) ref_mem[wa] = $urandom;
    need     = w || !hit;
    exp_lat  = need ? 3 + dly : 3;
    exp_data = w ? d : (hit ? rc_data[set] : ref_mem[wa]);
    exp_line = {1'b1, tg, (w ? d : ref_mem[wa])};

    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    wt = 0;
    while (!bus.req_ready && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    check_val("ready_wait", (wt < 100), 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_write = $urandom_range(0, 1);
    lat = 1;
    nmem = 0;
    nwr = 0;
    got_resp = 1'b0;
    while (lat < 60) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      if (lat == 1 || lat == 2) check_val("lu_set", bus.lu_set, set);
      if (bus.mem_req) begin
        nmem++;
        check_val("mem_addr", bus.mem_addr, wa);
        check_val("mem_we", bus.mem_we, w);
        if (w) check_val("mem_wdata", bus.mem_wdata, d);
        if (nmem == dly) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = w ? $urandom : ref_mem[wa];
        end
      end
      #1;
      if (bus.wr_en) begin
        nwr++;
        check_val("wr_set", bus.wr_set, set);
        check_val("wr_line", bus.wr_line, exp_line);
      end
      if (bus.resp_valid) begin
        got_resp = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    bus.mem_ack = 1'b0;
    check_val("resp_seen", got_resp, 1);
    check_val("latency", lat, exp_lat);
    if (!w) check_val("resp_rdata", bus.resp_rdata, exp_data);
    check_val("resp_vs_flush_done", bus.flush_done, 0);
    check_val("mem_req_cycles", nmem, need ? dly : 0);
    check_val("wr_count", nwr, need ? 1 : 0);
    if (need) begin
      rc_v[set]    = 1'b1;
      rc_tag[set]  = tg;
      rc_data[set] = w ? d : ref_mem[wa];
    end
    if (w) ref_mem[wa] = d;
    @(negedge clk);
    check_val("array_line", {arr_v[set], arr_tag[set], arr_data[set]},
              {rc_v[set], (rc_v[set] ? rc_tag[set] : arr_tag[set]),
               (rc_v[set] ? rc_data[set] : arr_data[set])});
  endtask

  initial begin
    int wt;
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.flush_req = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    model_clear();

    // Reset: every output low.
    repeat (3) @(negedge clk);
    check_val("rst_ctrl", {bus.req_ready, bus.resp_valid, bus.flush_done,
                           bus.wr_en, bus.mem_req, bus.mem_we}, 0);
    check_val("rst_wr_line", bus.wr_line, 0);
    check_val("rst_sets", {bus.wr_set, bus.lu_set}, 0);
    check_val("rst_mem_addr", bus.mem_addr, 0);
    check_val("rst_mem_wdata", bus.mem_wdata, 0);
    check_val("rst_rdata", bus.resp_rdata, 0);

    // Release: 8-cycle sweep, flush_done, then ready.
    rst = 1'b0;
    check_sweep();
    @(negedge clk);
    check_val("ready_after_flush", bus.req_ready, 1);

    // Load miss with 4-cycle memory wait, then a hit.
    ref_mem[32'h14] = 32'hDEAD_BEEF;
    do_req(1'b0, 32'h0000_0014, 32'h0, 4);
    check_val("set5_after_fill", {arr_v[5], arr_tag[5], arr_data[5]},
              {1'b1, 27'd0, 32'hDEAD_BEEF});
    do_req(1'b0, 32'h0000_0014, 32'h0, 2);

    // Store to a conflicting tag, then the original load misses again.
    do_req(1'b1, 32'h0000_0034, 32'hCAFE_0001, 3);
    check_val("set5_after_store", {arr_v[5], arr_tag[5], arr_data[5]},
              {1'b1, 27'd1, 32'hCAFE_0001});
    do_req(1'b0, 32'h0000_0014, 32'h0, 2);

    // Reset in the middle of a fetch.
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_0054;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    wt = 0;
    while (!bus.mem_req && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    check_val("fetch_reached", bus.mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_drops_mem_req", bus.mem_req, 0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    #1;
    check_val("late_ack_wr_en", bus.wr_en, 0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    rst = 1'b0;
    check_sweep();
    @(negedge clk);
    do_req(1'b0, 32'h0000_0014, 32'h0, 1);

    // Simultaneous flush_req and req_valid: flush first.
    bus.flush_req = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_0014;
    #1;
    check_val("ready_under_flush_req", bus.req_ready, 0);
    @(negedge clk);
    bus.flush_req = 1'b0;
    check_sweep();
    do_req(1'b0, 32'h0000_0014, 32'h0, 2);

    // Randomized traffic.
    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      a = ({$urandom_range(0, 3)} << 5) | ({$urandom_range(0, 7)} << 2) | {$urandom_range(0, 3)};
      do_req(($urandom_range(0, 2) == 0), a, $urandom, $urandom_range(1, 5));
      if (k % 20 == 19) do_flush();
      if (k % 13 == 5) begin
        bus.mem_ack = 1'b1;
        #1;
        check_val("idle_ack_wr_en", bus.wr_en, 0);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check_val("idle_ack_ready", bus.req_ready, 1);
        check_val("idle_ack_resp", bus.resp_valid, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
